// File: rtl/mem_arbiter.sv
// Two-port data-memory arbiter: combinational grant with a bounded-burst
// sticky priority, shared registered read data with single-cycle latency.
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] MaxHold = 4'(MAX_HOLD);

  logic       r_last;
  logic [3:0] r_holdCnt;
  logic       w_both;
  logic       w_pick1;
  logic       w_gnt0;
  logic       w_gnt1;
  logic       w_read;

  // Under contention the previous winner keeps the port until its burst
  // reaches MAX_HOLD; grants are masked while reset is held low.
  assign w_both  = req0 & req1;
  assign w_pick1 = w_both ? ((r_holdCnt < MaxHold) ? r_last : ~r_last) : req1;
  assign w_gnt0  = rst & (req0 | req1) & ~w_pick1;
  assign w_gnt1  = rst & (req0 | req1) & w_pick1;
  assign w_read  = (w_gnt0 & ~we0) | (w_gnt1 & ~we1);

  assign gnt0      = w_gnt0;
  assign gnt1      = w_gnt1;
  assign mem_addr  = w_gnt1 ? addr1 : addr0;
  assign mem_wdata = w_gnt1 ? wdata1 : wdata0;
  assign mem_we    = (w_gnt0 & we0) | (w_gnt1 & we1);

  // The reset owner is port 0 so that with an empty burst count port 0
  // wins the first contention after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last    <= 1'b0;
      r_holdCnt <= 4'd0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata     <= '0;
    end else begin
      if (w_gnt0 | w_gnt1) begin
        if (w_gnt1 == r_last) begin
          r_holdCnt <= (r_holdCnt == 4'd15) ? 4'd15 : r_holdCnt + 4'd1;
        end else begin
          r_last    <= w_gnt1;
          r_holdCnt <= 4'd1;
        end
      end else begin
        r_holdCnt <= 4'd0;
      end
      rvalid0 <= w_gnt0 & ~we0;
      rvalid1 <= w_gnt1 & ~we1;
      if (w_read) begin
        rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter, checked against a
// behavioural model of the arbitration rules and a shadow memory.
module tb_mem_arbiter;

  localparam int MaxHold = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, memWe;
  logic [31:0] rdata, memAddr, memWdata, memRdata;

  logic [31:0] hmem [16];
  logic [31:0] modelMem [16];

  int          checks = 0;
  int          errors = 0;
  int          owner;
  int          streak;
  int          lastGrant;
  logic        expRvalid0, expRvalid1;
  logic [31:0] expRdata;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(MaxHold)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .mem_addr(memAddr), .mem_wdata(memWdata),
    .mem_we(memWe), .mem_rdata(memRdata)
  );

  always #5 clk = ~clk;

  assign memRdata = hmem[memAddr[5:2]];

  // Harness data memory: combinational read, write on the rising edge.
  initial begin
    for (int i = 0; i < 16; i++) hmem[i] <= 32'h1000_0000 + i;
    forever begin
      @(posedge clk);
      if (memWe) hmem[memAddr[5:2]] <= memWdata;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    owner      = 0;
    streak     = 0;
    lastGrant  = -1;
    expRvalid0 = 1'b0;
    expRvalid1 = 1'b0;
    expRdata   = '0;
  endtask

  // Drive one cycle of requests, check every output against the model,
  // then advance the model across the coming rising edge.
  task automatic applyStimulus(input logic r0, input logic w0, input logic [31:0] a0,
                               input logic [31:0] d0, input logic r1, input logic w1,
                               input logic [31:0] a1, input logic [31:0] d1);
    int          g;
    logic [31:0] ea, ed;
    logic        ewe;
    @(negedge clk);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    #1;
    checkOutput("rvalid0", 64'(rvalid0), 64'(expRvalid0));
    checkOutput("rvalid1", 64'(rvalid1), 64'(expRvalid1));
    checkOutput("rdata", 64'(rdata), 64'(expRdata));
    if (r0 && r1) g = (streak < MaxHold) ? owner : 1 - owner;
    else if (r0)  g = 0;
    else if (r1)  g = 1;
    else          g = -1;
    ea  = (g == 1) ? a1 : a0;
    ed  = (g == 1) ? d1 : d0;
    ewe = (g == 0) ? w0 : (g == 1) ? w1 : 1'b0;
    checkOutput("gnt0", 64'(gnt0), 64'(g == 0));
    checkOutput("gnt1", 64'(gnt1), 64'(g == 1));
    checkOutput("mem_we", 64'(memWe), 64'(ewe));
    checkOutput("mem_addr", 64'(memAddr), 64'(ea));
    checkOutput("mem_wdata", 64'(memWdata), 64'(ed));
    lastGrant  = g;
    expRvalid0 = (g == 0) && !w0;
    expRvalid1 = (g == 1) && !w1;
    if (g < 0) begin
      streak = 0;
    end else begin
      if (g == owner) streak = (streak < 15) ? streak + 1 : 15;
      else begin
        owner  = g;
        streak = 1;
      end
      if (ewe) modelMem[ea[5:2]] = ed;
      else     expRdata = modelMem[ea[5:2]];
    end
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b0;
    #1;
    checkOutput("rst_gnt0", 64'(gnt0), 64'd0);
    checkOutput("rst_gnt1", 64'(gnt1), 64'd0);
    checkOutput("rst_mem_we", 64'(memWe), 64'd0);
    checkOutput("rst_rvalid", 64'({rvalid0, rvalid1}), 64'd0);
    checkOutput("rst_rdata", 64'(rdata), 64'd0);
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0;
    modelReset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic logic [31:0] randAddr();
    return {26'h0, 4'($urandom_range(0, 15)), 2'b00};
  endfunction

  logic [8:0] burstPattern;

  initial begin
    for (int i = 0; i < 16; i++) modelMem[i] = 32'h1000_0000 + i;
    modelReset();
    doReset();

    // Contention straight out of reset: port 0 first, data one cycle later.
    applyStimulus(1, 0, 32'h4, 0, 1, 0, 32'h8, 0);
    checkOutput("first_contention", 64'(lastGrant), 64'd0);

    // Burst limit with continuous contention.
    doReset();
    burstPattern = 9'b0_1111_0000;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1, 0, randAddr(), 0, 1, 0, randAddr(), 0);
      checkOutput("burst_gnt1", 64'(gnt1), 64'(burstPattern[i]));
    end
    idle();

    // Port 1 write followed by a read of the same word.
    applyStimulus(0, 0, 0, 0, 1, 1, 32'h10, 32'hDEADBEEF);
    checkOutput("wr_mem_we", 64'(memWe), 64'd1);
    applyStimulus(0, 0, 0, 0, 1, 0, 32'h10, 0);
    checkOutput("rd_mem_we", 64'(memWe), 64'd0);
    idle();
    checkOutput("rd_rvalid1", 64'(rvalid1), 64'd1);
    checkOutput("rd_rdata", 64'(rdata), 64'hDEADBEEF);

    // Idle gap clears the burst count; port 0 keeps priority.
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, randAddr(), 0, 0, 0, 0, 0);
    idle();
    applyStimulus(1, 0, randAddr(), 0, 1, 0, randAddr(), 0);
    checkOutput("gap_gnt0", 64'(gnt0), 64'd1);
    idle();

    // Reset lands between a granted read and its capture edge.
    applyStimulus(1, 0, 32'h14, 0, 0, 0, 0, 0);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("midrst_rvalid0", 64'(rvalid0), 64'd0);
    checkOutput("midrst_rdata", 64'(rdata), 64'd0);
    checkOutput("midrst_gnt0", 64'(gnt0), 64'd0);
    req0 = 1'b0;
    modelReset();
    @(negedge clk);
    rst = 1'b1;
    idle();
    checkOutput("after_rst_rvalid0", 64'(rvalid0), 64'd0);

    // Random traffic.
    for (int i = 0; i < 10000; i++) begin
      applyStimulus(1'($urandom), 1'($urandom), randAddr(), $urandom,
                    1'($urandom), 1'($urandom), randAddr(), $urandom);
      if (gnt0 && gnt1) checkOutput("mutex", 64'(gnt0 & gnt1), 64'd0);
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
